inst_fetch_q: RTL
=================

// Module: inst_fetch_q
// PURPOSE
//  Instruction fetch stage directly downstream of the instruction address register.
//  - Takes the current fetch address (iAddr) and issues single-word reads on the
//    instruction memory req/ack bus.
//  - Buffers returned words with their addresses in a small FIFO and presents them
//    to decode with a valid/ready handshake.
//  - Drives pcStall back to the PC hold mux and discards in-flight work on a
//    redirect (flush).
// PARAMETERS
//  AW     16  address width (matches iAddr)
//  DW     16  instruction word width
//  DEPTH  2   FIFO entries; power of 2, range 2..8
// PORTS
//  clk        in   1   clock, all state on posedge
//  nreset     in   1   reset, synchronous, active-low
//  iAddr      in   AW  next fetch address from PC register
//  fetchEn    in   1   permit new fetch requests
//  flush      in   1   redirect; asserted in same cycle as PC load from ALU
//  pcStall    out  1   1 = current iAddr not consumed, PC must hold
//  imemReq    out  1   memory request, held until imemAck
//  imemAddr   out  AW  request address, stable while imemReq=1
//  imemAck    in   1   memory completes request this cycle, imemData valid
//  imemData   in   DW  read data
//  instValid  out  1   FIFO head valid
//  instWord   out  DW  FIFO head instruction
//  instAddr   out  AW  FIFO head address
//  instReady  in   1   decode accepts head (pop when instValid & instReady)
// BEHAVIOUR
//  Reset values: imemReq=0, imemAddr=0, instValid=0, instWord=0, instAddr=0,
//   FIFO empty, pointers=0, FSM=IDLE.
//  FSM states:
//   IDLE : no request outstanding.
//   REQ  : imemReq=1.
//   DROP : imemReq=1; request orphaned by flush.
//  Definitions:
//   slots = DEPTH - count - (state==REQ)
//   issue = fetchEn & ~flush & (slots>0 after this cycle's pop) & (IDLE | REQ&imemAck)
//   pcStall = ~issue (combinational).
//  Issue: on issue, imemAddr<=iAddr and FSM->REQ.
//   - REQ&ack with no issue -> IDLE.
//   - Back-to-back: ack and issue in same cycle stays in REQ.
//  Push: REQ & imemAck & ~flush writes {imemAddr,imemData}. Push and pop in same
//   cycle both take effect; count unchanged.
//  Latency: iAddr sampled at edge N -> imemReq high in cycle N+1 -> ack earliest
//   N+1 -> instValid earliest N+2. Zero-wait memory sustains 1 instr/cycle.
//  Flush:
//   - Empties FIFO (count=0, pointers=0) at the edge; a same-cycle pop is void.
//   - REQ without ack -> DROP.
//   - REQ with ack -> data discarded, IDLE.
//   - DROP with ack -> IDLE. While in DROP, pcStall=1 and no pushes occur.
//   - Flush in IDLE only clears the FIFO.
//   - First post-flush fetch issues in the cycle after flush.
//  imemReq never drops before imemAck except on reset.
//  Reset mid-request: imemReq drops at the next edge. The memory side tolerates
//   the abandoned request.
//  Full FIFO: no issue, imemReq stays 0 until a pop frees a slot. A pop in cycle
//   N allows an issue in cycle N.
//  Pointer wrap is modulo DEPTH.
//  instWord/instAddr retain the last head value when instValid=0.
// CONFIGURATION
//  IFETCH_STALLCNT_EN defined:
//   - Adds output stallCnt[15:0], which counts cycles with instReady & ~instValid.
//   - Saturates at 16'hFFFF. Cleared by reset only; flush does not clear it.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. nreset=0 for 2 cycles, fetchEn=1 -> imemReq=0, instValid=0, pcStall=1
//     during reset.
//  2. imemAck tied 1, iAddr=0,1,2.., instReady=1 -> instValid from cycle 2,
//     instAddr 0,1,2 one per cycle, pcStall=0.
//  3. DEPTH=2, instReady=0 -> exactly 2 entries (addr 0,1), then imemReq=0,
//     pcStall=1. Raise instReady -> pops 0 then 1, fetch resumes at 2.
//  4. Ack latency 3, flush in cycle 1 of request with iAddr=0x0040 -> old data
//     never appears. Next imemAddr=0x0040. instAddr=0x0040 first valid.
//  5. Flush coincident with imemAck while FIFO holds 1 entry -> FIFO empty,
//     acked data dropped, instValid=0 next cycle.
//  6. IFETCH_STALLCNT_EN, ack latency 3, instReady=1 -> stallCnt=3 per
//     instruction after first; force 65536+ stalls -> stallCnt holds 16'hFFFF.

Source files
------------

// File: rtl/inst_fetch_q.sv
// ----------------------------------------------------------------------------
// inst_fetch_q
//   Instruction fetch stage sitting behind the instruction address register.
//   Issues single-word reads on the imem req/ack bus, buffers returned words
//   with their addresses in a DEPTH-entry FIFO and hands them to decode with a
//   valid/ready handshake. pcStall tells the PC hold mux whether the current
//   iAddr was consumed. flush discards buffered and in-flight work.
//
//   Optional feature macro: IFETCH_STALLCNT_EN adds stallCnt[15:0], a
//   saturating count of cycles where decode is ready but no instruction is
//   valid.
//
// Ports
//   clk, nreset          clock; synchronous active-low reset
//   iAddr     [AW]  in   next fetch address from PC register
//   fetchEn         in   permit new fetch requests
//   flush           in   redirect; drop FIFO contents and in-flight request
//   pcStall         out  1 = iAddr not consumed this cycle (combinational)
//   imemReq         out  memory request, held until imemAck
//   imemAddr  [AW]  out  request address
//   imemAck         in   memory returns imemData this cycle
//   imemData  [DW]  in   read data
//   instValid       out  FIFO head valid
//   instWord  [DW]  out  FIFO head instruction
//   instAddr  [AW]  out  FIFO head address
//   instReady       in   decode accepts head
//   stallCnt  [16]  out  (IFETCH_STALLCNT_EN only) decode-starved cycles
//
//   DEPTH must be a power of 2 in 2..8 (pointers wrap naturally).
// ----------------------------------------------------------------------------
module inst_fetch_q #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic [AW-1:0] iAddr,
   input  logic          fetchEn,
   input  logic          flush,
   output logic          pcStall,
   output logic          imemReq,
   output logic [AW-1:0] imemAddr,
   input  logic          imemAck,
   input  logic [DW-1:0] imemData,
   output logic          instValid,
   output logic [DW-1:0] instWord,
   output logic [AW-1:0] instAddr,
   input  logic          instReady
`ifdef IFETCH_STALLCNT_EN
   ,
   output logic [15:0]   stallCnt
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned EW = AW + DW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;

   logic [AW-1:0]   imem_addr_q;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            valid_q, valid_d;
   logic [EW-1:0]   head_q, head_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic            in_flight_c;
   logic            req_c;
   logic            pop_c;
   logic            push_c;
   logic            slot_ok_c;
   logic            issue_c;

   // Fetch decision: a new address may be taken when the bus is free (or
   // freeing this cycle) and a FIFO slot remains for it after the in-flight
   // word and this cycle's pop are accounted for.
   always_comb begin
      pop_c     = valid_q & instReady;
      push_c    = (state_q == ST_REQ) & imemAck & ~flush;
      slot_ok_c = (SW'(count_q) + SW'(state_q == ST_REQ)) < (SW'(DEPTH) + SW'(pop_c));
      issue_c   = nreset & fetchEn & ~flush & slot_ok_c &
                  ((state_q == ST_IDLE) | ((state_q == ST_REQ) & imemAck));
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!nreset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (issue_c) state_d = ST_REQ;
         ST_REQ: begin
            if (flush)        state_d = imemAck ? ST_IDLE : ST_DROP;
            else if (imemAck) state_d = issue_c ? ST_REQ : ST_IDLE;
         end
         ST_DROP: if (imemAck) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_c       = 1'b0;
      in_flight_c = 1'b0;
      case (state_q)
         ST_REQ: begin
            req_c       = 1'b1;
            in_flight_c = 1'b1;
         end
         ST_DROP: req_c = 1'b1;
         default: ;
      endcase
   end

   // FIFO next state; head output is a registered copy so it holds its last
   // value once the FIFO drains.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = PW'(wr_ptr_q + PW'(1));
         if (pop_c)  rd_ptr_d = PW'(rd_ptr_q + PW'(1));
         count_d = CW'(count_q + CW'(push_c) - CW'(pop_c));
      end
      valid_d = (count_d != '0);
      if (valid_d) begin
         // Pushing into an otherwise empty FIFO: the new word is not in mem yet.
         if (push_c && (count_q == CW'(pop_c))) head_d = {imem_addr_q, imemData};
         else                                     head_d = mem_q[rd_ptr_d];
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!nreset) begin
         imem_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         head_q      <= '0;
      end else begin
         if (issue_c) imem_addr_q <= iAddr;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   // FIFO storage; contents need no reset since only counted entries are read
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= {imem_addr_q, imemData};
   end

`ifdef IFETCH_STALLCNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating decode-starvation counter; only reset clears it
   always_ff @(posedge clk) begin
      if (!nreset)                                        stall_cnt_q <= '0;
      else if (instReady && !valid_q && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stallCnt = stall_cnt_q;
`endif

   assign pcStall   = ~issue_c;
   assign imemReq   = req_c;
   assign imemAddr  = imem_addr_q;
   assign instValid = valid_q;
   assign instAddr  = head_q[EW-1:DW];
   assign instWord  = head_q[DW-1:0];

   // in_flight_c mirrors the REQ state for readers of the FSM output block
   logic unused_c;
   assign unused_c = in_flight_c;

endmodule
